// File: rtl/align_shift_seq.sv
// align_shift_seq
// ---------------
// This block aligns an FP32 mantissa in the adder path, between exponent
// compare and mantissa add. It takes a 24-bit mantissa and an 8-bit shift
// amount and clamps the shift to 24. It then shifts right by at most 4 bits
// per cycle and ORs every bit shifted out into a sticky bit.
//
// Ports
//   clk         clock; all state updates on the rising edge
//   rst         synchronous, active-high reset
//   in_valid    upstream request valid
//   in_ready    block can accept (IDLE and rst low)
//   in_shift    unsigned right-shift amount, 0..255
//   in_mant     mantissa to align, including hidden bit
//   out_valid   result valid (DONE state)
//   out_ready   downstream accepts the result
//   out_mant    aligned mantissa (qualify with out_valid)
//   out_sticky  OR of all bits shifted out
//   out_ge24    requested shift was >= 24 and was clamped
module align_shift_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_shift,
    input  logic [23:0] in_mant,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] out_mant,
    output logic        out_sticky,
    output logic        out_ge24
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [4:0]  rem;
    logic [23:0] mant;
    logic        sticky;
    logic        ge24;

    logic        accept;
    logic        ge24_in;
    logic [4:0]  rem_in;
    logic [2:0]  step;
    logic [4:0]  rem_after;
    logic [23:0] drop_mask;

    // Request decode and per-cycle step. Below 24, in_shift fits in 5 bits,
    // so the low bits are the exact remaining count.
    // drop_mask selects the bits about to fall off the bottom this cycle.
    always_comb begin
        accept    = in_valid && in_ready;
        ge24_in   = (in_shift >= 8'd24);
        rem_in    = ge24_in ? 5'd24 : in_shift[4:0];
        step      = (rem > 5'd4) ? 3'd4 : rem[2:0];
        rem_after = rem - {2'b00, step};
        drop_mask = (24'd1 << step) - 24'd1;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (rem_in == 5'd0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (rem_after == 5'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers. Inputs are sampled only on the accept edge.
    // The result registers hold their value through DONE until the next load.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem    <= 5'd0;
            mant   <= 24'd0;
            sticky <= 1'b0;
            ge24   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem    <= rem_in;
                        mant   <= in_mant;
                        sticky <= 1'b0;
                        ge24   <= ge24_in;
                    end
                end
                SHIFT: begin
                    mant   <= mant >> step;
                    sticky <= sticky | (|(mant & drop_mask));
                    rem    <= rem_after;
                end
                default: begin
                end
            endcase
        end
    end

    // Output logic. in_ready is gated by rst so that no request is accepted
    // while reset is asserted.
    always_comb begin
        in_ready   = (state == IDLE) && !rst;
        out_valid  = (state == DONE);
        out_mant   = mant;
        out_sticky = sticky;
        out_ge24   = ge24;
    end

endmodule

// File: tb/tb_align_shift_seq.sv
// tb_align_shift_seq
// ------------------
// Testbench for align_shift_seq. It runs the directed cases first, then
// random requests. Each result is compared against a reference computed
// directly from the shift amount: clamp to 24, shift once, OR the dropped
// bits, and derive the expected latency.
module tb_align_shift_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_shift;
    logic [23:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_mant;
    logic        out_sticky;
    logic        out_ge24;

    int errors = 0;
    int checks = 0;

    align_shift_seq dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_shift   (in_shift),
        .in_mant    (in_mant),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_mant   (out_mant),
        .out_sticky (out_sticky),
        .out_ge24   (out_ge24)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports and counts a failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Runs one transaction. It is entered at a negedge with the block idle.
    // The result is held for bp cycles with out_ready low before it transfers.
    task automatic applyStimulus(input logic [7:0] shift, input logic [23:0] mant,
                                 input int bp);
        int          eff;
        int          exp_lat;
        logic [23:0] exp_mant;
        logic        exp_sticky;
        logic        exp_ge24;
        logic [31:0] full;
        int          edges;

        // Reference result
        exp_ge24   = (shift >= 8'd24);
        eff        = exp_ge24 ? 24 : int'(shift);
        full       = {8'd0, mant};
        exp_mant   = mant >> eff;
        exp_sticky = |(full & ((32'd1 << eff) - 32'd1));
        exp_lat    = 1 + (eff + 3) / 4;

        checkOutput("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid  = 1'b1;
        in_shift  = shift;
        in_mant   = mant;
        out_ready = (bp == 0);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        // Garbage on the inputs while busy must be ignored.
        in_valid = 1'($urandom);
        in_shift = 8'($urandom);
        in_mant  = 24'($urandom);
        while (out_valid !== 1'b1 && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            in_valid = 1'($urandom);
            in_shift = 8'($urandom);
            in_mant  = 24'($urandom);
        end
        checkOutput("latency", edges, exp_lat);
        checkOutput("out_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("out_mant", {8'd0, out_mant}, {8'd0, exp_mant});
        checkOutput("out_sticky", {31'd0, out_sticky}, {31'd0, exp_sticky});
        checkOutput("out_ge24", {31'd0, out_ge24}, {31'd0, exp_ge24});
        checkOutput("in_ready_busy", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_mant", {8'd0, out_mant}, {8'd0, exp_mant});
            checkOutput("bp_sticky", {31'd0, out_sticky}, {31'd0, exp_sticky});
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("post_xfer_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("post_xfer_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_shift  = 8'd0;
        in_mant   = 24'd0;
        out_ready = 1'b1;
        $display("[TB] reset");
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_out_mant", {8'd0, out_mant}, 32'd0);
        checkOutput("rst_out_sticky", {31'd0, out_sticky}, 32'd0);
        checkOutput("rst_out_ge24", {31'd0, out_ge24}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("rst_release_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);

        $display("[TB] directed cases");
        applyStimulus(8'd0,   24'hABCDEF, 0);
        applyStimulus(8'd5,   24'h800001, 0);
        applyStimulus(8'd8,   24'hFFFF00, 0);
        applyStimulus(8'd200, 24'h000001, 0);
        applyStimulus(8'd24,  24'h000001, 0);
        applyStimulus(8'd5,   24'h800001, 5);
        applyStimulus(8'd8,   24'hFFFF00, 0);

        $display("[TB] reset during SHIFT");
        in_valid = 1'b1;
        in_shift = 8'd20;
        in_mant  = 24'hFFFFFF;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_out_mant", {8'd0, out_mant}, 32'd0);
        checkOutput("midrst_out_sticky", {31'd0, out_sticky}, 32'd0);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("midrst_release_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(8'd3, 24'h00000F, 0);

        $display("[TB] random cases");
        for (int n = 0; n < 40; n++) begin
            logic [7:0] s;
            if (n % 2 == 0) s = 8'($urandom_range(0, 30));
            else            s = 8'($urandom);
            applyStimulus(s, 24'($urandom), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
